// File: rtl/instruction_fetch.sv
// Fetch stage: issues four byte reads to a 1-cycle-latency memory and presents the
// little-endian 32-bit instruction to decode over a valid/ready handshake.
module instruction_fetch #(
    parameter int unsigned         ADDR_W   = 14,
    parameter logic [ADDR_W-1:0]   RESET_PC = 14'h1000
) (
    input  logic              clk,
    input  logic              reset,
    output logic [ADDR_W-1:0] mem_address,
    input  logic [7:0]        mem_read_data,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [31:0]       instr_data,
    output logic [ADDR_W-1:0] instr_pc
);

    typedef enum logic {FETCH, VALID} state_t;

    state_t            state, state_next;
    logic [ADDR_W-1:0] fetch_pc;
    logic [2:0]        issue_idx;
    logic [1:0]        cap_idx;
    logic              pend;
    logic [23:0]       asm_word;
    logic              capture_last;
    logic              transfer;

    // issue_idx is zero outside FETCH, so this also yields fetch_pc in VALID
    always_comb begin
        mem_address = fetch_pc + ADDR_W'(issue_idx);
    end

    always_comb begin
        capture_last = (state == FETCH) && pend && (cap_idx == 2'd3);
        transfer     = (state == VALID) && instr_ready;
        state_next   = state;
        if (redirect_valid)
            state_next = FETCH;
        else if (capture_last)
            state_next = VALID;
        else if (transfer)
            state_next = FETCH;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= FETCH;
        else
            state <= state_next;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc    <= RESET_PC;
            issue_idx   <= '0;
            cap_idx     <= '0;
            pend        <= 1'b0;
            asm_word    <= '0;
            instr_valid <= 1'b0;
            instr_data  <= '0;
            instr_pc    <= '0;
        end else if (redirect_valid) begin
            // in-flight byte and partial word are abandoned; lanes get overwritten later
            fetch_pc    <= redirect_pc;
            issue_idx   <= '0;
            cap_idx     <= '0;
            pend        <= 1'b0;
            instr_valid <= 1'b0;
        end else if (state == FETCH) begin
            if (issue_idx < 3'd4) begin
                issue_idx <= issue_idx + 3'd1;
                pend      <= 1'b1;
            end else begin
                pend <= 1'b0;
            end
            if (pend) begin
                cap_idx <= cap_idx + 2'd1;
                case (cap_idx)
                    2'd0:    asm_word[7:0]   <= mem_read_data;
                    2'd1:    asm_word[15:8]  <= mem_read_data;
                    2'd2:    asm_word[23:16] <= mem_read_data;
                    default: ;
                endcase
                if (capture_last) begin
                    instr_data  <= {mem_read_data, asm_word};
                    instr_pc    <= fetch_pc;
                    instr_valid <= 1'b1;
                    issue_idx   <= '0;
                end
            end
        end else if (instr_ready) begin
            fetch_pc    <= fetch_pc + ADDR_W'(3'd4);
            instr_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch with a behavioural 16 KiB registered-read memory.
module tb_instruction_fetch;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [13:0] mem_address;
    logic [7:0]  mem_read_data;
    logic        redirect_valid = 1'b0;
    logic [13:0] redirect_pc = '0;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [31:0] instr_data;
    logic [13:0] instr_pc;

    logic [7:0]  mem [0:16383];
    int          checks = 0;
    int          fails = 0;
    int          xfers = 0;

    always #5 clk = ~clk;

    instruction_fetch #(.ADDR_W(14), .RESET_PC(14'h1000)) dut (
        .clk            (clk),
        .reset          (reset),
        .mem_address    (mem_address),
        .mem_read_data  (mem_read_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr_data     (instr_data),
        .instr_pc       (instr_pc)
    );

    always @(posedge clk) mem_read_data <= mem[mem_address];
    always @(posedge clk) if (instr_valid && instr_ready) xfers <= xfers + 1;

    typedef struct {
        logic [13:0] pc;
        logic [7:0]  b0, b1, b2, b3;
        logic [31:0] exp_data;
        logic [13:0] exp_next;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic redirect_to(input logic [13:0] pc);
        redirect_pc    = pc;
        redirect_valid = 1'b1;
        tick();
        redirect_valid = 1'b0;
    endtask

    task automatic wait_valid(input string name);
        int n = 0;
        while (!instr_valid && n < 20) begin
            tick();
            n++;
        end
        check({name, " latency"}, n, 5);
    endtask

    task automatic put4(input logic [13:0] pc, input logic [7:0] b0, input logic [7:0] b1,
                        input logic [7:0] b2, input logic [7:0] b3);
        logic [13:0] a;
        a = pc;          mem[a] = b0;
        a = pc + 14'd1;  mem[a] = b1;
        a = pc + 14'd2;  mem[a] = b2;
        a = pc + 14'd3;  mem[a] = b3;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t vecs[4];
        logic [31:0] held_data;
        int          x0;

        vecs[0] = '{pc: 14'd100,   b0: 8'h01, b1: 8'h02, b2: 8'h03, b3: 8'h04,
                    exp_data: 32'h04030201, exp_next: 14'd104};
        vecs[1] = '{pc: 14'd16382, b0: 8'hAA, b1: 8'hBB, b2: 8'hCC, b3: 8'hDD,
                    exp_data: 32'hDDCCBBAA, exp_next: 14'd2};
        vecs[2] = '{pc: 14'd16383, b0: 8'h11, b1: 8'h22, b2: 8'h33, b3: 8'h44,
                    exp_data: 32'h44332211, exp_next: 14'd3};
        vecs[3] = '{pc: 14'd555,   b0: 8'hF0, b1: 8'h0F, b2: 8'h80, b3: 8'h7E,
                    exp_data: 32'h7E800FF0, exp_next: 14'd559};

        for (int i = 0; i < 16384; i++) mem[i] = 8'h00;
        put4(14'd4096,  8'h12, 8'h00, 8'h00, 8'h00);
        put4(14'd8192,  8'h34, 8'h00, 8'h00, 8'h00);
        put4(14'd12288, 8'h56, 8'h00, 8'h00, 8'h00);

        // Reset state and first fetch
        #12;
        check("reset valid", instr_valid, 0);
        check("reset data", instr_data, 0);
        check("reset pc", instr_pc, 0);
        check("reset addr", mem_address, 4096);
        reset = 1'b0;
        instr_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            check("fetch addr", mem_address, 4096 + k);
            tick();
        end
        check("valid not early", instr_valid, 0);
        tick();
        check("t1 valid", instr_valid, 1);
        check("t1 data", instr_data, 32'h00000012);
        check("t1 pc", instr_pc, 4096);
        tick();
        check("t1 valid drop", instr_valid, 0);
        check("t1 next addr", mem_address, 4100);

        // Stall with ready low
        instr_ready = 1'b0;
        redirect_to(14'd4096);
        wait_valid("t2");
        for (int k = 0; k < 10; k++) begin
            check("stall valid", instr_valid, 1);
            check("stall data", instr_data, 32'h00000012);
            check("stall pc", instr_pc, 4096);
            check("stall addr", mem_address, 4096);
            tick();
        end
        x0 = xfers;
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        check("t2 one transfer", xfers, x0 + 1);
        check("t2 valid drop", instr_valid, 0);
        check("t2 next addr", mem_address, 4100);

        // Redirect mid-fetch
        redirect_to(14'd4096);
        tick();
        tick();
        check("t3 pre-redirect addr", mem_address, 4098);
        redirect_to(14'd8192);
        check("t3 redirect addr", mem_address, 8192);
        wait_valid("t3");
        check("t3 data", instr_data, 32'h00000034);
        check("t3 pc", instr_pc, 8192);

        // Table of fetch targets, including wraparound and unaligned PCs
        for (int i = 0; i < 4; i++) begin
            put4(vecs[i].pc, vecs[i].b0, vecs[i].b1, vecs[i].b2, vecs[i].b3);
            redirect_to(vecs[i].pc);
            wait_valid("vec");
            check("vec data", instr_data, vecs[i].exp_data);
            check("vec pc", instr_pc, vecs[i].pc);
            instr_ready = 1'b1;
            tick();
            instr_ready = 1'b0;
            check("vec next addr", mem_address, vecs[i].exp_next);
        end

        // Asynchronous reset between edges while an instruction is held
        redirect_to(14'd8192);
        wait_valid("t5 pre");
        #3;
        reset = 1'b1;
        #1;
        check("t5 async valid", instr_valid, 0);
        check("t5 async data", instr_data, 0);
        check("t5 async addr", mem_address, 4096);
        #1;
        reset = 1'b0;

        // Transfer and redirect on the same edge
        wait_valid("t6 pre");
        check("t6 pre data", instr_data, 32'h00000012);
        held_data = instr_data;
        x0 = xfers;
        instr_ready = 1'b1;
        redirect_to(14'd12288);
        instr_ready = 1'b0;
        check("t6 one transfer", xfers, x0 + 1);
        check("t6 valid drop", instr_valid, 0);
        check("t6 redirect addr", mem_address, 12288);
        wait_valid("t6");
        check("t6 data", instr_data, 32'h00000056);
        check("t6 pc", instr_pc, 12288);
        check("t6 data changed", instr_data == held_data, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
